// File: rtl/stream_chk_pkg.sv
// Shared types and constants for the stream sequence checker and its
// matching transmit-side generator.
package stream_chk_pkg;

    localparam int MODE_INC  = 0;
    localparam int MODE_LFSR = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Galois feedback masks for a right-shifting LFSR (bit 0 shifts out).
    localparam logic [31:0] LFSR_TAPS_8  = 32'h0000_00B8; // x^8+x^6+x^5+x^4+1
    localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_B400; // x^16+x^14+x^13+x^11+1
    localparam logic [31:0] LFSR_TAPS_24 = 32'h00E1_0000; // x^24+x^23+x^22+x^17+1
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003; // x^32+x^22+x^2+x+1

    // Widths without a table entry fall back to a two-tap mask; it still
    // never locks up from a nonzero seed, but the period is not guaranteed
    // to be maximal.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return LFSR_TAPS_8;
            16:      return LFSR_TAPS_16;
            24:      return LFSR_TAPS_24;
            32:      return LFSR_TAPS_32;
            default: return (32'd1 << (width - 1)) | 32'd1;
        endcase
    endfunction

endpackage

// File: rtl/seq_gen.sv
// Expected-sequence generator: incrementing counter or Galois LFSR.
// Shared by the receive checker and the transmit stream source.
module seq_gen
    import stream_chk_pkg::*;
#(
    parameter int                DATA_W = 16,
    parameter int                MODE   = MODE_INC,
    parameter logic [DATA_W-1:0] SEED   = DATA_W'(1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              advance,
    output logic [DATA_W-1:0] value
);

    localparam logic [DATA_W-1:0] TAPS = DATA_W'(lfsr_taps(DATA_W));

    logic [DATA_W-1:0] value_nxt;

    // Next value of the sequence; counter wraps naturally at all-ones.
    always_comb begin
        value_nxt = value;
        if (MODE == MODE_LFSR) begin
            value_nxt = (value >> 1) ^ (value[0] ? TAPS : '0);
        end else begin
            value_nxt = value + DATA_W'(1);
        end
    end

    // Sequence register: load restarts at SEED, advance steps once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= SEED;
        end else if (load) begin
            value <= SEED;
        end else if (advance) begin
            value <= value_nxt;
        end
    end

endmodule

// File: rtl/stream_seq_checker.sv
// Receive-side checker at the tail of a CDC path: compares accepted words
// against the expected sequence, counts words and mismatches, applies
// periodic backpressure and reports pass/fail or a watchdog timeout.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | after reset, waiting for the first start pulse
//   RUN   | accepting words, watchdog counting idle cycles
//   DONE  | result held (done/pass/timeout sticky) until the next start
module stream_seq_checker
    import stream_chk_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                MODE      = MODE_INC,
    parameter logic [DATA_W-1:0] SEED      = DATA_W'(1),
    parameter int                N_WORDS   = 256,
    parameter int                TIMEOUT   = 1024,
    parameter int                BP_PERIOD = 0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  rx_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [DATA_W-1:0] first_err_got,
    output logic [DATA_W-1:0] first_err_exp
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int BP_W = (BP_PERIOD > 1) ? $clog2(BP_PERIOD) : 1;

    state_t            state;
    state_t            state_nxt;
    logic              run_start;
    logic              last_accept;
    logic              wd_expire;
    logic              accept;
    logic              mismatch;
    logic              bp_hold;
    logic [WD_W-1:0]   wdog;
    logic [CNT_W-1:0]  err_cnt_nxt;
    logic [DATA_W-1:0] expected;

    // Free-running backpressure counter; ready drops on its last count.
    if (BP_PERIOD > 0) begin : g_bp
        logic [BP_W-1:0] bp_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                bp_cnt <= '0;
            end else if (bp_cnt == BP_W'(BP_PERIOD - 1)) begin
                bp_cnt <= '0;
            end else begin
                bp_cnt <= bp_cnt + BP_W'(1);
            end
        end

        assign bp_hold = (bp_cnt == BP_W'(BP_PERIOD - 1));
    end else begin : g_no_bp
        assign bp_hold = 1'b0;
    end

    assign in_ready    = (state == RUN) && !bp_hold;
    assign busy        = (state == RUN);
    assign accept      = in_valid && in_ready;
    assign mismatch    = accept && (in_data != expected);
    assign err_cnt_nxt = (mismatch && (err_cnt != '1)) ? err_cnt + CNT_W'(1) : err_cnt;

    seq_gen #(
        .DATA_W (DATA_W),
        .MODE   (MODE),
        .SEED   (SEED)
    ) u_seq_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (run_start),
        .advance (accept),
        .value   (expected)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; a final accept takes priority over watchdog expiry.
    always_comb begin
        state_nxt   = state;
        run_start   = 1'b0;
        last_accept = 1'b0;
        wd_expire   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = RUN;
                    run_start = 1'b1;
                end
            end
            RUN: begin
                if (accept) begin
                    if (rx_cnt == CNT_W'(N_WORDS - 1)) begin
                        last_accept = 1'b1;
                        state_nxt   = DONE;
                    end
                end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                    wd_expire = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters, first-error capture, watchdog and sticky result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt        <= '0;
            err_cnt       <= '0;
            first_err_got <= '0;
            first_err_exp <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            wdog          <= '0;
        end else if (run_start) begin
            rx_cnt        <= '0;
            err_cnt       <= '0;
            first_err_got <= '0;
            first_err_exp <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            timeout       <= 1'b0;
            wdog          <= '0;
        end else if (state == RUN) begin
            if (accept) begin
                rx_cnt  <= rx_cnt + CNT_W'(1);
                err_cnt <= err_cnt_nxt;
                wdog    <= '0;
                if (mismatch && (err_cnt == '0)) begin
                    first_err_got <= in_data;
                    first_err_exp <= expected;
                end
            end else begin
                wdog <= wdog + WD_W'(1);
            end
            if (last_accept) begin
                done <= 1'b1;
                pass <= (err_cnt_nxt == '0);
            end
            if (wd_expire) begin
                done    <= 1'b1;
                timeout <= 1'b1;
                pass    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_seq_checker.sv
// Scoreboard bench for stream_seq_checker: three configurations share one
// clock and reset; each run pushes its predicted result and a monitor
// compares when done rises.
`timescale 1ns/1ps
module tb_stream_seq_checker;

    localparam int NI  = 3;
    localparam int CW  = 16;
    localparam int TMO = 16;
    // inst 0: 16-bit counter, 8 words; inst 1: 8-bit counter from 0xFE;
    // inst 2: 16-bit LFSR, 100 words, backpressure period 3
    localparam int WID [NI] = '{16, 8, 16};
    localparam int MD  [NI] = '{0, 0, 1};
    localparam int SD  [NI] = '{1, 'hFE, 1};
    localparam int NWD [NI] = '{8, 4, 100};

    typedef struct {
        int          inst;
        int          rx;
        int          err;
        logic [15:0] fg;
        logic [15:0] fe;
        bit          to;
        bit          ps;
        int          lchk;   // 0: done latency, 1: latency + run length, 2: idle run length
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           st   [NI];
    logic           vld  [NI];
    logic [15:0]    dat  [NI];
    logic           rdy  [NI];
    logic           bsy  [NI];
    logic           dn   [NI];
    logic           ps   [NI];
    logic           to   [NI];
    logic [CW-1:0]  rxc  [NI];
    logic [CW-1:0]  erc  [NI];
    logic [15:0]    fgot [NI];
    logic [15:0]    fexp [NI];
    logic [15:0]    a_fg, a_fe, c_fg, c_fe;
    logic [7:0]     b_fg, b_fe;

    assign fgot[0] = a_fg;
    assign fexp[0] = a_fe;
    assign fgot[1] = {8'h00, b_fg};
    assign fexp[1] = {8'h00, b_fe};
    assign fgot[2] = c_fg;
    assign fexp[2] = c_fe;

    stream_seq_checker #(.DATA_W(16), .MODE(0), .SEED(16'd1), .N_WORDS(8),
                         .TIMEOUT(TMO), .BP_PERIOD(0), .CNT_W(CW)) u_a (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .in_valid(vld[0]), .in_data(dat[0]),
        .in_ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .pass(ps[0]), .timeout(to[0]),
        .rx_cnt(rxc[0]), .err_cnt(erc[0]), .first_err_got(a_fg), .first_err_exp(a_fe));

    stream_seq_checker #(.DATA_W(8), .MODE(0), .SEED(8'hFE), .N_WORDS(4),
                         .TIMEOUT(TMO), .BP_PERIOD(0), .CNT_W(CW)) u_b (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .in_valid(vld[1]), .in_data(dat[1][7:0]),
        .in_ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .pass(ps[1]), .timeout(to[1]),
        .rx_cnt(rxc[1]), .err_cnt(erc[1]), .first_err_got(b_fg), .first_err_exp(b_fe));

    stream_seq_checker #(.DATA_W(16), .MODE(1), .SEED(16'd1), .N_WORDS(100),
                         .TIMEOUT(TMO), .BP_PERIOD(3), .CNT_W(CW)) u_c (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .in_valid(vld[2]), .in_data(dat[2]),
        .in_ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .pass(ps[2]), .timeout(to[2]),
        .rx_cnt(rxc[2]), .err_cnt(erc[2]), .first_err_got(c_fg), .first_err_exp(c_fe));

    int   total = 0;
    int   bad   = 0;
    exp_t sbq [$];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", nm, got, want);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    // Reference sequence: value + 1 modulo 2^width, or one step of the
    // polynomial x^16+x^14+x^13+x^11+1 in Galois form.
    function automatic logic [15:0] seq_next(input int k, input logic [15:0] x);
        logic [15:0] m;
        m = 16'((32'd1 << WID[k]) - 1);
        if (MD[k] == 0) return (x + 16'd1) & m;
        return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    // ---------------- monitor ----------------
    int   cyc = 0;
    logic pdone    [NI];
    int   last_acc [NI];
    int   busy_cyc [NI];
    int   last_low = -1;
    int   lows     = 0;
    int   gap_bad  = 0;
    exp_t me;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                pdone[k]    = 1'b0;
                last_acc[k] = -100;
                busy_cyc[k] = 0;
            end else begin
                if (st[k]) begin
                    busy_cyc[k] = 0;
                    if (k == 2) last_low = -1;
                end
                if (bsy[k]) busy_cyc[k]++;
                if (vld[k] && rdy[k]) last_acc[k] = cyc;
                if (k == 2 && bsy[2] && !rdy[2]) begin
                    if (last_low >= 0 && (cyc - last_low) != 3) gap_bad++;
                    last_low = cyc;
                    lows++;
                end
                if (!dn[k]) check("pass_without_done", ps[k], 1'b0);
                if (dn[k] && !pdone[k]) begin
                    if (sbq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done: inst=%0d got done with empty scoreboard", k);
                    end else begin
                        me = sbq.pop_front();
                        check("done_inst", k, me.inst);
                        check("rx_cnt", rxc[k], me.rx);
                        check("err_cnt", erc[k], me.err);
                        check("first_err_got", fgot[k], me.fg);
                        check("first_err_exp", fexp[k], me.fe);
                        check("timeout", to[k], me.to);
                        check("pass", ps[k], me.ps);
                        if (me.lchk == 2) begin
                            check("idle_run_len", busy_cyc[k], TMO);
                        end else begin
                            check("done_latency", cyc - last_acc[k], 1);
                        end
                        if (me.lchk == 1)
                            check("bp_run_len", (busy_cyc[k] >= 149 && busy_cyc[k] <= 151), 1);
                    end
                end
                pdone[k] = dn[k];
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start(input int k);
        st[k] = 1'b1;
        @(posedge clk); #1;
        st[k] = 1'b0;
    endtask

    task automatic send_word(input int k, input logic [15:0] w, input int idle);
        bit acc;
        int tries;
        vld[k] = 1'b0;
        repeat (idle) begin @(posedge clk); #1; end
        vld[k] = 1'b1;
        dat[k] = w;
        acc    = 1'b0;
        tries  = 0;
        while (!acc && tries < 40) begin
            @(negedge clk);
            acc = rdy[k];
            @(posedge clk); #1;
            tries++;
        end
        if (!acc) fail("accept_wait");
        vld[k] = 1'b0;
    endtask

    task automatic wait_done(input int k);
        int n;
        n = 0;
        while (!dn[k] && n < 400) begin @(posedge clk); #1; n++; end
        if (!dn[k]) fail("done_wait");
        @(posedge clk); #1;
    endtask

    task automatic do_run(input int k, input int err_pct, input int idle_max,
                          input int inj_idx, input logic [15:0] inj_val, input int lchk);
        logic [15:0] e, w, m, fg, fe;
        int          nerr;
        logic [15:0] words [$];
        exp_t        x;
        m    = 16'((32'd1 << WID[k]) - 1);
        e    = 16'(SD[k]);
        nerr = 0;
        fg   = '0;
        fe   = '0;
        for (int i = 0; i < NWD[k]; i++) begin
            w = e;
            if (i == inj_idx) w = inj_val;
            else if ($urandom_range(0, 99) < err_pct) w = e ^ 16'($urandom_range(1, int'(m)));
            if (w != e) begin
                if (nerr == 0) begin fg = w; fe = e; end
                nerr++;
            end
            words.push_back(w);
            e = seq_next(k, e);
        end
        x.inst = k; x.rx = NWD[k]; x.err = nerr; x.fg = fg; x.fe = fe;
        x.to = 1'b0; x.ps = (nerr == 0); x.lchk = lchk;
        sbq.push_back(x);
        pulse_start(k);
        foreach (words[i]) send_word(k, words[i], (idle_max == 0) ? 0 : int'($urandom_range(0, idle_max)));
        wait_done(k);
    endtask

    task automatic do_timeout(input int k);
        exp_t x;
        x.inst = k; x.rx = 0; x.err = 0; x.fg = '0; x.fe = '0;
        x.to = 1'b1; x.ps = 1'b0; x.lchk = 2;
        sbq.push_back(x);
        pulse_start(k);
        wait_done(k);
        sbq.push_back(x);
        pulse_start(k);
        check("restart_clears_done", dn[k], 1'b0);
        check("restart_clears_timeout", to[k], 1'b0);
        check("restart_busy", bsy[k], 1'b1);
        wait_done(k);
    endtask

    task automatic check_zero(input int k);
        check("zero_in_ready", rdy[k], 0);
        check("zero_busy", bsy[k], 0);
        check("zero_done", dn[k], 0);
        check("zero_pass", ps[k], 0);
        check("zero_timeout", to[k], 0);
        check("zero_rx_cnt", rxc[k], 0);
        check("zero_err_cnt", erc[k], 0);
        check("zero_first_got", fgot[k], 0);
        check("zero_first_exp", fexp[k], 0);
    endtask

    task automatic do_abort();
        pulse_start(0);
        for (int i = 0; i < 3; i++) send_word(0, 16'(i + 1), 0);
        check("pre_abort_rx_cnt", rxc[0], 3);
        #1 rst_n = 1'b0;
        #1;
        check_zero(0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            st[k] = 1'b0; vld[k] = 1'b0; dat[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) check_zero(k);
        @(negedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_run(0, 0, 0, -1, 16'h0, 0);          // clean 1..8 back-to-back
        do_run(0, 0, 0, 3, 16'h00FF, 0);        // word 4 corrupted
        repeat (4) do_run(0, 15, 3, -1, 16'h0, 0);
        do_run(1, 0, 0, -1, 16'h0, 0);          // FE,FF,00,01 wrap
        repeat (4) do_run(1, 20, 2, -1, 16'h0, 0);
        do_run(2, 0, 0, -1, 16'h0, 1);          // LFSR, valid held high, backpressure
        do_run(2, 5, 2, -1, 16'h0, 0);
        do_timeout(0);
        do_abort();
        do_run(0, 0, 0, -1, 16'h0, 0);          // clean run after reset abort

        check("scoreboard_drained", sbq.size(), 0);
        check("bp_gap_violations", gap_bad, 0);
        check("bp_lows_seen", (lows > 0), 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
